// File: rtl/bit_alu_pkg.sv
// Shared types for the bit-serial ALU: opcodes, sequencer states and width default.
package bit_alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    AND  = 3'd2,
    OR   = 3'd3,
    XOR  = 3'd4,
    MOVA = 3'd5,
    MOVB = 3'd6,
    CMP  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Subtract-class ops invert B and start with carry-in 1 (no borrow).
  function automatic logic is_sub(input op_t op);
    return (op == SUB) || (op == CMP);
  endfunction

  function automatic logic is_arith(input op_t op);
    return (op == ADD) || (op == SUB) || (op == CMP);
  endfunction

endpackage

// File: rtl/bit_alu_if.sv
// Request/serial-data/flag bundle between the bit-serial ALU and its users.
// o_overflow exists only when BIT_ALU_OVF_EN is defined.
interface bit_alu_if;
  import bit_alu_pkg::*;

  logic i_start;
  op_t  i_op;
  logic i_a_bit;
  logic i_b_bit;
  logic o_shift;
  logic o_write;
  logic o_result_bit;
  logic o_busy;
  logic o_done;
  logic o_carry;
  logic o_zero;
`ifdef BIT_ALU_OVF_EN
  logic o_overflow;
`endif

  modport master (
    output i_start, i_op, i_a_bit, i_b_bit,
    input  o_shift, o_write, o_result_bit, o_busy, o_done, o_carry, o_zero
`ifdef BIT_ALU_OVF_EN
    , input o_overflow
`endif
  );

  modport slave (
    input  i_start, i_op, i_a_bit, i_b_bit,
    output o_shift, o_write, o_result_bit, o_busy, o_done, o_carry, o_zero
`ifdef BIT_ALU_OVF_EN
    , output o_overflow
`endif
  );

endinterface

// File: rtl/bit_alu_slice.sv
// One-bit ALU slice: opcode decode plus full adder, purely combinational.
module bit_alu_slice
  import bit_alu_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  op_t  op,
  output logic r,
  output logic cout
);

  logic bx;
  logic sum;
  logic carry;

  always_comb begin
    bx    = is_sub(op) ? ~b : b;
    sum   = a ^ bx ^ cin;
    carry = (a & bx) | (cin & (a ^ bx));
    r     = 1'b0;
    cout  = 1'b0;
    case (op)
      ADD, SUB, CMP: begin
        r    = sum;
        cout = carry;
      end
      AND:     r = a & b;
      OR:      r = a | b;
      XOR:     r = a ^ b;
      MOVA:    r = a;
      MOVB:    r = b;
      default: r = 1'b0;
    endcase
  end

endmodule

// File: rtl/bit_alu.sv
// Bit-serial ALU sequencer driving an LSB-first register file for WIDTH cycles per op.
// Define BIT_ALU_OVF_EN to add the signed-overflow flag output.
module bit_alu
  import bit_alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic       i_clk,
  input logic       i_rst,
  bit_alu_if.slave  bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t        state;
  op_t           op_q;
  logic          carry_q;
  logic          zacc_q;
  logic [CW-1:0] cnt;
  logic          carry_flag;
  logic          zero_flag;
  logic          r;
  logic          cout;
  logic          run;
  logic          last;

  bit_alu_slice u_slice (
    .a    (bus.i_a_bit),
    .b    (bus.i_b_bit),
    .cin  (carry_q),
    .op   (op_q),
    .r    (r),
    .cout (cout)
  );

  assign run  = (state == RUN);
  assign last = run && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      op_q       <= ADD;
      carry_q    <= 1'b0;
      zacc_q     <= 1'b0;
      cnt        <= '0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            state   <= RUN;
            op_q    <= bus.i_op;
            carry_q <= is_sub(bus.i_op);
            zacc_q  <= 1'b1;
            cnt     <= '0;
          end
        end
        RUN: begin
          carry_q <= cout;
          zacc_q  <= zacc_q & ~r;
          cnt     <= cnt + CW'(1);
          if (last) begin
            state      <= DONE;
            carry_flag <= cout;
            zero_flag  <= zacc_q & ~r;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BIT_ALU_OVF_EN
  logic ovf_flag;

  // MSB carry-in is carry_q during the last RUN cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      ovf_flag <= 1'b0;
    else if (last)
      ovf_flag <= is_arith(op_q) ? (carry_q ^ cout) : 1'b0;
  end

  assign bus.o_overflow = ovf_flag;
`endif

  // CMP recirculates A so the destination is preserved; flags still see the subtract bit.
  assign bus.o_result_bit = run ? ((op_q == CMP) ? bus.i_a_bit : r) : 1'b0;
  assign bus.o_shift      = run;
  assign bus.o_write      = run;
  assign bus.o_busy       = run;
  assign bus.o_done       = (state == DONE);
  assign bus.o_carry      = carry_flag;
  assign bus.o_zero       = zero_flag;

endmodule

// File: tb/tb_bit_alu.sv
// Scoreboard bench for bit_alu: directed ops push expectations, a monitor checks on o_done.
module tb_bit_alu;
  import bit_alu_pkg::*;

  typedef struct {
    string       name;
    logic [7:0]  res;
    logic        c;
    logic        z;
    logic        v;
    int unsigned done_cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  int unsigned cyc;
  int unsigned checks;
  int unsigned failures;
  exp_t        sbq[$];

  bit_alu_if bus ();

  bit_alu #(.WIDTH(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic run_op(input string nm, input op_t op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] res, input logic c, input logic z, input logic v,
                        input bit hold);
    exp_t e;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_op    = op;
    e.name = nm; e.res = res; e.c = c; e.z = z; e.v = v; e.done_cyc = cyc + 9;
    sbq.push_back(e);
    @(negedge clk);
    if (hold) bus.i_op = AND;
    else      bus.i_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.i_a_bit = a[k];
      bus.i_b_bit = b[k];
      @(negedge clk);
    end
    bus.i_start = 1'b0;
    bus.i_a_bit = 1'b0;
    bus.i_b_bit = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_shift"},  {31'd0, bus.o_shift},      32'd0);
    chk({tag, "_write"},  {31'd0, bus.o_write},      32'd0);
    chk({tag, "_busy"},   {31'd0, bus.o_busy},       32'd0);
    chk({tag, "_done"},   {31'd0, bus.o_done},       32'd0);
    chk({tag, "_carry"},  {31'd0, bus.o_carry},      32'd0);
    chk({tag, "_zero"},   {31'd0, bus.o_zero},       32'd0);
    chk({tag, "_result"}, {31'd0, bus.o_result_bit}, 32'd0);
`ifdef BIT_ALU_OVF_EN
    chk({tag, "_ovf"},    {31'd0, bus.o_overflow},   32'd0);
`endif
  endtask

  // Monitor: collects serial bits while shifting, pops and compares on o_done.
  initial begin
    logic [7:0]  col;
    int unsigned nbits;
    exp_t        e;
    col = '0;
    nbits = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        nbits = 0;
        col = '0;
      end else begin
        if (bus.o_shift) begin
          chk("write_during_run", {31'd0, bus.o_write}, 32'd1);
          chk("busy_during_run",  {31'd0, bus.o_busy},  32'd1);
          if (nbits < 8) col[nbits] = bus.o_result_bit;
          nbits++;
        end
        if (bus.o_done) begin
          if (sbq.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sbq.pop_front();
            chk({e.name, "_result"},     {24'd0, col},       {24'd0, e.res});
            chk({e.name, "_shift_cnt"},  nbits,              32'd8);
            chk({e.name, "_done_cycle"}, cyc,                e.done_cyc);
            chk({e.name, "_carry"},      {31'd0, bus.o_carry}, {31'd0, e.c});
            chk({e.name, "_zero"},       {31'd0, bus.o_zero},  {31'd0, e.z});
`ifdef BIT_ALU_OVF_EN
            chk({e.name, "_ovf"},        {31'd0, bus.o_overflow}, {31'd0, e.v});
`endif
          end
          nbits = 0;
          col = '0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_op    = ADD;
    bus.i_a_bit = 1'b0;
    bus.i_b_bit = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0;
    @(negedge clk);

    //      name         op    A      B      result c     z     v     hold
    run_op("add_3c_05",  ADD,  8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("add_ff_01",  ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

    // Abort an ADD at RUN cycle 4; flags from the previous op (1/1) must clear.
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_op    = ADD;
    @(negedge clk);
    bus.i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.i_a_bit = k[0];
      bus.i_b_bit = 1'b1;
      @(negedge clk);
    end
    chk("pre_reset_busy", {31'd0, bus.o_busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("midrun_reset");
    rst = 1'b0;
    bus.i_a_bit = 1'b0;
    bus.i_b_bit = 1'b0;
    @(negedge clk);
    chk_quiet("post_reset_idle");

    run_op("add_12_34",  ADD,  8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("add_7f_01",  ADD,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("sub_05_05",  SUB,  8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("sub_03_05",  SUB,  8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sub_80_01",  SUB,  8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("cmp_10_20",  CMP,  8'h10, 8'h20, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("cmp_80_80",  CMP,  8'h80, 8'h80, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("and_ca_0f",  AND,  8'hCA, 8'h0F, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("or_a0_05",   OR,   8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("xor_ff_ff",  XOR,  8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("mova_5a",    MOVA, 8'h5A, 8'hFF, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("movb_00",    MOVB, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Start held through RUN/DONE with the opcode switched to AND: one ADD only.
    run_op("hold_add",   ADD,  8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) begin
      chk("hold_no_requeue_busy", {31'd0, bus.o_busy}, 32'd0);
      @(negedge clk);
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_alu.md
Name: bit_alu

Overview:
- Bit-serial ALU and sequencer that sits directly upstream of the 8-bit bit-serial register file.
- Consumes operand bits LSB-first, one per clock: A comes from the register file serial output, B from a second serial source.
- Produces one result bit per clock for the register file serial write input.
- Generates the register file shift and write enables for one complete WIDTH-bit operation, then reports flags.

Parameters:
- WIDTH, 8, operand width in bits; equals the number of shift cycles per operation.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  request an operation; sampled in IDLE only.
- i_op  in  3  opcode from bit_alu_pkg::op_t; latched when the start is accepted.
- i_a_bit  in  1  operand A serial bit, LSB-first.
- i_b_bit  in  1  operand B serial bit, LSB-first.
- o_shift  out  1  shift enable to the register file.
- o_write  out  1  write enable to the register file.
- o_result_bit  out  1  serial result bit to the register file.
- o_busy  out  1  high while an operation is running.
- o_done  out  1  one-cycle completion pulse.
- o_carry  out  1  carry flag.
- o_zero  out  1  zero flag.

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when i_start=1.
  - RUN lasts exactly WIDTH cycles, tracked by bit counter cnt = 0..WIDTH-1.
  - RUN -> DONE on the edge where cnt=WIDTH-1.
  - DONE -> IDLE unconditionally after 1 cycle.
- On an accepted start:
  - op_q <= i_op.
  - carry_q <= 1 for SUB/CMP, else 0.
  - zacc_q <= 1.
  - cnt <= 0.
- In RUN:
  - o_shift=1 and o_busy=1.
  - Bit k of A/B must be valid in the k-th RUN cycle.
  - o_result_bit is combinational from i_a_bit, i_b_bit, carry_q and op_q, so the register file samples it on the same edge.
- Opcodes:
  - ADD: a + b + c.
  - SUB: a + ~b + c.
  - AND, OR, XOR: bitwise.
  - MOVA: a.
  - MOVB: b.
  - CMP: computes SUB internally, but o_result_bit = i_a_bit, so the destination recirculates unchanged.
- o_write=1 during every RUN cycle, for all opcodes. With write low the register file would shift in zeros and destroy the destination.
- Each RUN cycle:
  - carry_q <= carry-out of the bit (logic ops and MOV: 0).
  - zacc_q <= zacc_q & ~r, where r is the computed bit. For CMP, r is the subtract bit, not the recirculated bit.
- Flags: o_carry and o_zero are registered, updated on the RUN->DONE edge, and held until the next DONE.
  - For SUB/CMP, carry=1 means no borrow (A >= B unsigned).
- Latency: start accepted at edge T → o_shift high in cycles T+1..T+WIDTH → o_done high in cycle T+WIDTH+1.
- Boundary conditions:
  - i_start in RUN or DONE: ignored, not queued.
  - i_op changes after start: no effect.
  - Reset at any time, including mid-RUN: next cycle IDLE, o_shift=o_write=o_busy=o_done=0, o_carry=0, o_zero=0, cnt=0. A partially shifted register-file value is the system's responsibility.
- Reset values: every output 0 (o_result_bit 0 in IDLE).
- Outside RUN: o_shift=0 and o_write=0.

Optional Feature:
- Macro: BIT_ALU_OVF_EN.
- Defined: adds output port o_overflow (1 bit).
  - On the RUN->DONE edge, for ADD/SUB/CMP: o_overflow = carry-in XOR carry-out of the MSB bit (signed overflow).
  - For other ops: 0.
  - Reset value 0.
- Undefined: port and logic absent. All other behaviour identical.

Decomposition:
- bit_alu_pkg:
  - op_t enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4, MOVA=5, MOVB=6, CMP=7.
  - state_t enum: IDLE, RUN, DONE.
  - DEFAULT_WIDTH=8.
- One natural sub-module: bit_alu_slice, combinational. Inputs a, b, cin, op. Outputs r, cout. Contains the per-bit op decode and full adder. FSM, counter and flags stay in bit_alu.

Test Plan:
- ADD A=0x3C, B=0x05, start → o_shift high exactly 8 cycles, serial result 0x41, o_done at T+9, carry=0, zero=0.
- ADD A=0xFF, B=0x01 → result 0x00, carry=1, zero=1. With BIT_ALU_OVF_EN: overflow=0. Separately, 0x7F+0x01 gives overflow=1.
- SUB A=0x05, B=0x05 → result 0x00, carry=1, zero=1. Then SUB A=0x03, B=0x05 → 0xFE, carry=0, zero=0.
- CMP A=0x10, B=0x20 → written bits reproduce 0x10, o_write=1 all 8 cycles, carry=0, zero=0.
- i_start held high through the operation, with i_op switched to AND after acceptance → exactly one 8-cycle op using the original opcode; next op starts only from IDLE, after DONE.
- i_rst asserted at RUN cycle 4 of an ADD → next cycle all outputs 0, state IDLE; a new start runs a full 8 cycles with correct result.
